// File: rtl/l2_cache.sv
// l2_cache: shared direct-mapped, write-through, no-write-allocate L2 serving an
// I-port and a D-port through a single backing-memory port.
module l2_cache #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        iop,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic [DATA_W-1:0] idata_in,
  output logic              i_ready,
  output logic [DATA_W-1:0] idata_out,
  output logic              i_valid,
  input  logic [1:0]        dop,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] ddata_in,
  output logic              d_ready,
  output logic [DATA_W-1:0] ddata_out,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned SETS  = 1 << IDX_W;
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state_q, state_d;
  req_t              dp_req_q, dp_req_d, ip_req_q, ip_req_d;
  logic              dp_pend_q, dp_pend_d, ip_pend_q, ip_pend_d;
  logic              cur_d_q, cur_d_d;
  logic              ready_q, ready_d;
  logic              i_valid_q, i_valid_d, d_valid_q, d_valid_d;
  logic [DATA_W-1:0] idata_q, idata_d, ddata_q, ddata_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [SETS-1:0]   vld_q, vld_d;
  logic [TAG_W-1:0]  tag_q [SETS];
  logic [TAG_W-1:0]  tag_d [SETS];
  logic [DATA_W-1:0] dat_q [SETS];
  logic [DATA_W-1:0] dat_d [SETS];

  logic [IDX_W-1:0]  i_idx_c, d_idx_c, f_idx_c;
  logic [TAG_W-1:0]  i_tag_c, d_tag_c;
  logic              i_hit_c, d_hit_c;
  logic              i_rd_c, i_wr_c, d_rd_c, d_wr_c;
  logic              i_need_c, d_need_c;
  logic              unused_addr_bits;

  // Request decode and hit detection against the pre-update array
  assign i_idx_c  = iaddr[IDX_W+1:2];
  assign d_idx_c  = daddr[IDX_W+1:2];
  assign i_tag_c  = iaddr[ADDR_W-1:IDX_W+2];
  assign d_tag_c  = daddr[ADDR_W-1:IDX_W+2];
  assign f_idx_c  = mem_addr_q[IDX_W+1:2];
  assign i_hit_c  = vld_q[i_idx_c] && (tag_q[i_idx_c] == i_tag_c);
  assign d_hit_c  = vld_q[d_idx_c] && (tag_q[d_idx_c] == d_tag_c);
  assign i_rd_c   = ready_q && (iop == OP_READ);
  assign i_wr_c   = ready_q && (iop == OP_WRITE);
  assign d_rd_c   = ready_q && (dop == OP_READ);
  assign d_wr_c   = ready_q && (dop == OP_WRITE);
  assign i_need_c = i_wr_c || (i_rd_c && !i_hit_c);
  assign d_need_c = d_wr_c || (d_rd_c && !d_hit_c);
  assign unused_addr_bits = ^{iaddr[1:0], daddr[1:0], mem_addr_q[1:0]};

  // Next-state, array update and output computation
  always_comb begin
    state_d     = state_q;
    dp_req_d    = dp_req_q;
    ip_req_d    = ip_req_q;
    dp_pend_d   = dp_pend_q;
    ip_pend_d   = ip_pend_q;
    cur_d_d     = cur_d_q;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    idata_d     = idata_q;
    ddata_d     = ddata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    vld_d       = vld_q;
    tag_d       = tag_q;
    dat_d       = dat_q;

    case (state_q)
      S_IDLE: begin
        // D read sees the old word; I write lands first so a D write wins
        if (d_rd_c && d_hit_c) begin
          d_valid_d = 1'b1;
          ddata_d   = dat_q[d_idx_c];
        end
        if (i_wr_c && i_hit_c) dat_d[i_idx_c] = idata_in;
        if (d_wr_c && d_hit_c) dat_d[d_idx_c] = ddata_in;
        if (i_rd_c && i_hit_c) begin
          i_valid_d = 1'b1;
          idata_d   = (d_wr_c && d_hit_c && (d_idx_c == i_idx_c)) ? ddata_in : dat_q[i_idx_c];
        end
        if (d_need_c) begin
          dp_pend_d = 1'b1;
          dp_req_d  = '{we: d_wr_c, addr: {daddr[ADDR_W-1:2], 2'b00}, wdata: ddata_in};
        end
        if (i_need_c) begin
          ip_pend_d = 1'b1;
          ip_req_d  = '{we: i_wr_c, addr: {iaddr[ADDR_W-1:2], 2'b00}, wdata: idata_in};
        end
        if (d_need_c) begin
          state_d     = S_MEM;
          cur_d_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = d_wr_c;
          mem_addr_d  = {daddr[ADDR_W-1:2], 2'b00};
          mem_wdata_d = ddata_in;
        end else if (i_need_c) begin
          state_d     = S_MEM;
          cur_d_d     = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = i_wr_c;
          mem_addr_d  = {iaddr[ADDR_W-1:2], 2'b00};
          mem_wdata_d = idata_in;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            vld_d[f_idx_c] = 1'b1;
            tag_d[f_idx_c] = mem_addr_q[ADDR_W-1:IDX_W+2];
            dat_d[f_idx_c] = mem_rdata;
          end
          if (cur_d_q) begin
            dp_pend_d = 1'b0;
            d_valid_d = 1'b1;
            if (!mem_we_q) ddata_d = mem_rdata;
          end else begin
            ip_pend_d = 1'b0;
            i_valid_d = 1'b1;
            if (!mem_we_q) idata_d = mem_rdata;
          end
        end
      end
      S_RESP: begin
        if (dp_pend_q) begin
          state_d     = S_MEM;
          cur_d_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = dp_req_q.we;
          mem_addr_d  = dp_req_q.addr;
          mem_wdata_d = dp_req_q.wdata;
        end else if (ip_pend_q) begin
          state_d     = S_MEM;
          cur_d_d     = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = ip_req_q.we;
          mem_addr_d  = ip_req_q.addr;
          mem_wdata_d = ip_req_q.wdata;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // Control, pending work, outputs and line valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dp_req_q    <= '0;
      ip_req_q    <= '0;
      dp_pend_q   <= 1'b0;
      ip_pend_q   <= 1'b0;
      cur_d_q     <= 1'b0;
      ready_q     <= 1'b1;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      idata_q     <= '0;
      ddata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      dp_req_q    <= dp_req_d;
      ip_req_q    <= ip_req_d;
      dp_pend_q   <= dp_pend_d;
      ip_pend_q   <= ip_pend_d;
      cur_d_q     <= cur_d_d;
      ready_q     <= ready_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
      idata_q     <= idata_d;
      ddata_q     <= ddata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      vld_q       <= vld_d;
    end
  end

  // Tag/data payload; meaningless while the valid bit is clear
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    dat_q <= dat_d;
  end

  assign i_ready   = ready_q;
  assign d_ready   = ready_q;
  assign i_valid   = i_valid_q;
  assign d_valid   = d_valid_q;
  assign idata_out = idata_q;
  assign ddata_out = ddata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_l2_cache.sv
// Bench for l2_cache: directed scenarios plus random two-port traffic checked
// against a transaction-level cache/memory model.
module tb_l2_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  iop, dop;
  logic [31:0] iaddr, idata_in, daddr, ddata_in;
  logic        i_ready, i_valid, d_ready, d_valid;
  logic [31:0] idata_out, ddata_out;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  l2_cache dut (
    .clk(clk), .rst(rst),
    .iop(iop), .iaddr(iaddr), .idata_in(idata_in),
    .i_ready(i_ready), .idata_out(idata_out), .i_valid(i_valid),
    .dop(dop), .daddr(daddr), .ddata_in(ddata_in),
    .d_ready(d_ready), .ddata_out(ddata_out), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mop_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference cache state and memories (model view and bus view)
  bit          m_vld [64];
  logic [23:0] m_tag [64];
  logic [31:0] m_dat [64];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] last_i, last_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] bus_get(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 64; k++) m_vld[k] = 1'b0;
    last_i = '0;
    last_d = '0;
  endtask

  // One cycle of requests on both ports, then follow it to completion
  task automatic txn(input logic [1:0] iop_v, input logic [31:0] ia, input logic [31:0] iw_v,
                     input logic [1:0] dop_v, input logic [31:0] da, input logic [31:0] dw_v,
                     input int lat);
    bit ir, iwr, dr, dwr, ihit, dhit, i_imm, d_imm;
    int ii, di, w, fi;
    logic [31:0] exp_i, exp_d, exp_r;
    mop_t op;
    mop_t mq[$];
    ir  = (iop_v == 2'b01);
    iwr = (iop_v == 2'b10);
    dr  = (dop_v == 2'b01);
    dwr = (dop_v == 2'b10);
    ii  = int'(ia[7:2]);
    di  = int'(da[7:2]);
    ihit = m_vld[ii] && (m_tag[ii] == ia[31:8]);
    dhit = m_vld[di] && (m_tag[di] == da[31:8]);
    i_imm = ir && ihit;
    d_imm = dr && dhit;
    exp_i = '0;
    exp_d = '0;
    if (d_imm) exp_d = m_dat[di];
    if (iwr && ihit) m_dat[ii] = iw_v;
    if (dwr && dhit) m_dat[di] = dw_v;
    if (i_imm) exp_i = m_dat[ii];
    if (dwr || (dr && !dhit)) mq.push_back('{1'b1, dwr, {da[31:2], 2'b00}, dw_v});
    if (iwr || (ir && !ihit)) mq.push_back('{1'b0, iwr, {ia[31:2], 2'b00}, iw_v});

    iop = iop_v; iaddr = ia; idata_in = iw_v;
    dop = dop_v; daddr = da; ddata_in = dw_v;
    @(negedge clk);
    iop = 2'b00;
    dop = 2'b00;
    check("imm_i_valid", 32'(i_valid), 32'(i_imm));
    check("imm_d_valid", 32'(d_valid), 32'(d_imm));
    if (i_imm) begin check("imm_i_data", idata_out, exp_i); last_i = exp_i; end
    if (d_imm) begin check("imm_d_data", ddata_out, exp_d); last_d = exp_d; end
    check("imm_ready", 32'(d_ready & i_ready), (mq.size() == 0) ? 32'd1 : 32'd0);

    for (int k = 0; k < mq.size(); k++) begin
      op = mq[k];
      w = 0;
      while (!mem_req && w < 4) begin @(negedge clk); w++; end
      check("mem_req_up", 32'(mem_req), 32'd1);
      if (!mem_req) break;
      check("mem_we", 32'(mem_we), 32'(op.we));
      check("mem_addr", mem_addr, op.addr);
      if (op.we) check("mem_wdata", mem_wdata, op.wdata);
      for (int c = 0; c < lat; c++) begin
        @(negedge clk);
        check("mem_hold_req", 32'(mem_req), 32'd1);
        check("mem_hold_addr", mem_addr, op.addr);
      end
      if (mem_we) begin
        bus_mem[mem_addr] = mem_wdata;
        mem_rdata = $urandom;
      end else begin
        mem_rdata = bus_get(mem_addr);
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (op.we) begin
        ref_mem[op.addr] = op.wdata;
      end else begin
        exp_r = ref_get(op.addr);
        fi = int'(op.addr[7:2]);
        m_vld[fi] = 1'b1;
        m_tag[fi] = op.addr[31:8];
        m_dat[fi] = exp_r;
        if (op.is_d) last_d = exp_r; else last_i = exp_r;
      end
      check("resp_mem_req", 32'(mem_req), 32'd0);
      if (op.is_d) begin
        check("resp_d_valid", 32'(d_valid), 32'd1);
        check("resp_i_valid", 32'(i_valid), 32'd0);
        check("resp_d_data", ddata_out, last_d);
      end else begin
        check("resp_i_valid", 32'(i_valid), 32'd1);
        check("resp_d_valid", 32'(d_valid), 32'd0);
        check("resp_i_data", idata_out, last_i);
      end
    end

    w = 0;
    while (!(i_ready && d_ready) && w < 6) begin @(negedge clk); w++; end
    check("ready_back", 32'(i_ready & d_ready), 32'd1);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] t, x, lo;
    t  = 32'($urandom_range(0, 3));
    x  = 32'($urandom_range(0, 2));
    lo = 32'($urandom_range(0, 3));
    return (t << 8) | (x << 2) | lo;
  endfunction

  initial begin
    int w;
    rst = 1'b1;
    iop = 2'b00; dop = 2'b00;
    iaddr = '0; daddr = '0; idata_in = '0; ddata_in = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    bus_mem[32'h100] = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_valids", 32'({i_valid, d_valid}), 32'd0);
    check("rst_data", idata_out | ddata_out, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(i_ready & d_ready), 32'd1);

    // Cold read miss, then the same address hits
    txn(2'b00, 32'h0, 32'h0, 2'b01, 32'h100, 32'h0, 3);
    check("t1_ddata", ddata_out, 32'hDEAD_BEEF);
    txn(2'b00, 32'h0, 32'h0, 2'b01, 32'h100, 32'h0, 0);
    check("t2_ddata", ddata_out, 32'hDEAD_BEEF);

    // Same-cycle D write and I read of one line: I sees the new data
    txn(2'b01, 32'h100, 32'h0, 2'b10, 32'h100, 32'h1234_5678, 2);
    check("t3_idata", idata_out, 32'h1234_5678);
    check("t3_memimg", bus_get(32'h100), 32'h1234_5678);

    // Two misses to one set: D fetched first, I's line ends resident
    txn(2'b01, 32'h400, 32'h0, 2'b01, 32'h800, 32'h0, 1);
    txn(2'b00, 32'h0, 32'h0, 2'b01, 32'h400, 32'h0, 0);
    txn(2'b00, 32'h0, 32'h0, 2'b01, 32'h800, 32'h0, 1);

    // Write miss does not allocate
    txn(2'b00, 32'h0, 32'h0, 2'b10, 32'h204, 32'hCAFE_F00D, 2);
    txn(2'b00, 32'h0, 32'h0, 2'b01, 32'h204, 32'h0, 1);
    check("t5_ddata", ddata_out, 32'hCAFE_F00D);

    // Stray ack while idle does nothing
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    check("stray_ack_valid", 32'({i_valid, d_valid}), 32'd0);
    check("stray_ack_req", 32'(mem_req), 32'd0);

    // Reset while a fetch is outstanding drops it and invalidates the array
    txn(2'b01, 32'h40C, 32'h0, 2'b00, 32'h0, 32'h0, 0);
    dop = 2'b01; daddr = 32'h500;
    @(negedge clk);
    dop = 2'b00;
    check("abort_req_up", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_valids", 32'({i_valid, d_valid}), 32'd0);
    check("abort_ready", 32'(i_ready & d_ready), 32'd1);
    check("abort_data", ddata_out, 32'd0);
    w = 0;
    repeat (3) begin
      @(negedge clk);
      if (i_valid || d_valid || mem_req) w++;
    end
    check("abort_quiet", 32'(w), 32'd0);
    txn(2'b01, 32'h40C, 32'h0, 2'b00, 32'h0, 32'h0, 1);

    // Random two-port traffic over a small address pool
    for (int n = 0; n < 300; n++) begin
      txn(2'($urandom_range(0, 3)), rnd_addr(), $urandom,
          2'($urandom_range(0, 3)), rnd_addr(), $urandom,
          int'($urandom_range(0, 3)));
    end

    foreach (ref_mem[a]) check("mem_image", bus_get(a), ref_mem[a]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
